// File: rtl/i_buffer.sv
// i_buffer: small circular FIFO of raw RV32I words between fetch and the
// scoreboard. Decodes the head entry and issues it in order when the
// scoreboard partition for its class (ALU or LS) has room. Unsupported
// opcodes are dropped and flagged with a one-cycle bad_inst pulse.
module i_buffer #(
  parameter int unsigned DEPTH_WIDTH = 2,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [DATA_WIDTH-1:0] if_inst,
  output logic                  if_ready,
  input  logic                  flush,
  input  logic                  sb_vacant_ALU,
  input  logic                  sb_vacant_LS,
  output logic                  sb_valid,
  output logic [6:0]            sb_opt,
  output logic [2:0]            sb_funct,
  output logic [4:0]            sb_rs1,
  output logic [4:0]            sb_rs2,
  output logic [4:0]            sb_rd,
  output logic [DATA_WIDTH-1:0] sb_imm,
  output logic                  bad_inst
);

  localparam int unsigned DEPTH = 2 ** DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]   CNT_FULL = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]   CNT_ONE  = (DEPTH_WIDTH + 1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = DEPTH_WIDTH'(1);

  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] r_head;
  logic [DEPTH_WIDTH-1:0] r_tail;
  logic [DEPTH_WIDTH:0]   r_count;
  logic                   r_bad;

  logic [DATA_WIDTH-1:0] w_inst;
  logic [6:0]            w_op;
  logic                  w_is_alu;
  logic                  w_is_ls;
  logic                  w_has_rs2;
  logic                  w_has_rd;
  logic                  w_nonempty;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_push;

  assign w_inst     = r_mem[r_head];
  assign w_op       = w_inst[6:0];
  assign w_nonempty = (r_count != '0);

  // Ready depends only on the registered count, so a pop frees a slot one cycle later.
  assign if_ready = (r_count != CNT_FULL);

  // Classify the head opcode and build the sign-extended immediate.
  always_comb begin
    w_is_alu  = 1'b0;
    w_is_ls   = 1'b0;
    w_has_rs2 = 1'b0;
    w_has_rd  = 1'b0;
    sb_imm    = '0;
    case (w_op)
      OP_R: begin
        w_is_alu  = 1'b1;
        w_has_rs2 = 1'b1;
        w_has_rd  = 1'b1;
      end
      OP_I: begin
        w_is_alu = 1'b1;
        w_has_rd = 1'b1;
        sb_imm   = {{(DATA_WIDTH - 12){w_inst[31]}}, w_inst[31:20]};
      end
      OP_B: begin
        w_is_alu  = 1'b1;
        w_has_rs2 = 1'b1;
        sb_imm    = {{(DATA_WIDTH - 13){w_inst[31]}}, w_inst[31], w_inst[7],
                     w_inst[30:25], w_inst[11:8], 1'b0};
      end
      OP_L: begin
        w_is_ls  = 1'b1;
        w_has_rd = 1'b1;
        sb_imm   = {{(DATA_WIDTH - 12){w_inst[31]}}, w_inst[31:20]};
      end
      OP_S: begin
        w_is_ls   = 1'b1;
        w_has_rs2 = 1'b1;
        sb_imm    = {{(DATA_WIDTH - 12){w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      end
      default: ;
    endcase
  end

  assign sb_opt   = w_op;
  assign sb_funct = w_inst[14:12];
  assign sb_rs1   = w_inst[19:15];
  assign sb_rs2   = w_has_rs2 ? w_inst[24:20] : 5'd0;
  assign sb_rd    = w_has_rd ? w_inst[11:7] : 5'd0;

  // Vacancy is combinational from the scoreboard, so issue is too.
  assign sb_valid = w_nonempty && !flush &&
                    ((w_is_alu && sb_vacant_ALU) || (w_is_ls && sb_vacant_LS));
  assign w_drop   = w_nonempty && !flush && !w_is_alu && !w_is_ls;
  assign w_pop    = sb_valid || w_drop;
  assign w_push   = if_valid && if_ready && !flush;
  assign bad_inst = r_bad;

  // Head/tail/count bookkeeping; flush clears everything and discards a coincident push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_ONE;
      if (w_pop)  r_head <= r_head + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Entry storage, written at the tail on every accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem <= '{default: '0};
    end else if (w_push) begin
      r_mem[r_tail] <= if_inst;
    end
  end

  // bad_inst is high for the cycle after an unsupported head is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bad <= 1'b0;
    end else begin
      r_bad <= w_drop;
    end
  end

endmodule

// File: tb/tb_i_buffer.sv
// Testbench for i_buffer: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the buffer.
module tb_i_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = '0;
  logic        flush = 1'b0;
  logic        va = 1'b0;
  logic        vl = 1'b0;

  logic        if_ready;
  logic        sb_valid;
  logic [6:0]  sb_opt;
  logic [2:0]  sb_funct;
  logic [4:0]  sb_rs1;
  logic [4:0]  sb_rs2;
  logic [4:0]  sb_rd;
  logic [31:0] sb_imm;
  logic        bad_inst;

  i_buffer #(.DEPTH_WIDTH(2), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_valid      (if_valid),
    .if_inst       (if_inst),
    .if_ready      (if_ready),
    .flush         (flush),
    .sb_vacant_ALU (va),
    .sb_vacant_LS  (vl),
    .sb_valid      (sb_valid),
    .sb_opt        (sb_opt),
    .sb_funct      (sb_funct),
    .sb_rs1        (sb_rs1),
    .sb_rs2        (sb_rs2),
    .sb_rd         (sb_rd),
    .sb_imm        (sb_imm),
    .bad_inst      (bad_inst)
  );

  always #5 clk = ~clk;

  // Reference model: queued words in order, and the pending bad_inst pulse.
  logic [31:0] q[$];
  logic        m_bad = 1'b0;
  int          checks = 0;
  int          passes = 0;

  // 1 = ALU class, 2 = LS class, 0 = unsupported.
  function automatic int cls(input logic [31:0] w);
    case (w[6:0])
      7'b1100011, 7'b0010011, 7'b0110011: return 1;
      7'b0000011, 7'b0100011:             return 2;
      default:                            return 0;
    endcase
  endfunction

  function automatic logic exp_valid();
    if (q.size() == 0 || flush) return 1'b0;
    return (cls(q[0]) == 1 && va) || (cls(q[0]) == 2 && vl);
  endfunction

  // Expected {opt, funct, rs1, rs2, rd, imm}, immediates built arithmetically.
  function automatic logic [56:0] exp_fields(input logic [31:0] w);
    logic [6:0]  op;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    int          v;
    op  = w[6:0];
    rs2 = (op == 7'b0110011 || op == 7'b1100011 || op == 7'b0100011) ? w[24:20] : 5'd0;
    rd  = (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011) ? w[11:7] : 5'd0;
    case (op)
      7'b0010011, 7'b0000011: begin
        v = int'(w[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'b0100011: begin
        v = int'(w[31:25]) * 32 + int'(w[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'b1100011: begin
        v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      default: v = 0;
    endcase
    imm = 32'(v);
    return {op, w[14:12], w[19:15], rs2, rd, imm};
  endfunction

  function automatic logic [31:0] rand_word(input bit allow_bad);
    logic [6:0]  ops [7] = '{7'b1100011, 7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011,
                             7'b0110111, 7'b1101111};
    logic [31:0] r;
    int          n;
    n = allow_bad ? 7 : 5;
    r = $urandom();
    r[6:0] = ops[$urandom_range(n - 1, 0)];
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven, then
  // move to just after the edge.
  task automatic tick();
    logic pushed;
    logic drop;
    logic pop;
    pushed = if_valid && (q.size() != DEPTH) && !flush;
    if (flush) begin
      q.delete();
      m_bad = 1'b0;
    end else begin
      drop = (q.size() != 0) && (cls(q[0]) == 0);
      pop  = exp_valid() || drop;
      m_bad = drop;
      if (pop) void'(q.pop_front());
      if (pushed) q.push_back(if_inst);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (if_ready !== 1'b1) $display("FAIL reset_if_ready: got %b want 1", if_ready);
    else passes++;
    checks++;
    if (bad_inst !== 1'b0) $display("FAIL reset_bad_inst: got %b want 0", bad_inst);
    else passes++;
    va = 1'b1;
    vl = 1'b1;
    #1;
    checks++;
    if (sb_valid !== 1'b0) $display("FAIL reset_sb_valid: got %b want 0", sb_valid);
    else passes++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    va = 1'b0;
    vl = 1'b0;
    q.delete();
    m_bad = 1'b0;
  endtask

  task automatic test_single();
    if_valid = 1'b1;
    if_inst  = 32'h00500093;
    va = 1'b1;
    @(negedge clk);
    checks++;
    if (sb_valid !== 1'b0) $display("FAIL single_empty_valid: got %b want 0", sb_valid);
    else passes++;
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sb_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", sb_valid);
    else passes++;
    checks++;
    if ({sb_opt, sb_funct, sb_rs1, sb_rs2, sb_rd, sb_imm} !==
        {7'b0010011, 3'b000, 5'd0, 5'd0, 5'd1, 32'd5})
      $display("FAIL single_fields: got %h %h %0d %0d %0d %h want 13 0 0 0 1 00000005",
               sb_opt, sb_funct, sb_rs1, sb_rs2, sb_rd, sb_imm);
    else passes++;
    tick();
    @(negedge clk);
    checks++;
    if (sb_valid !== 1'b0 || if_ready !== 1'b1)
      $display("FAIL single_drained: got valid=%b ready=%b want 0 1", sb_valid, if_ready);
    else passes++;
    tick();
    va = 1'b0;
  endtask

  task automatic test_ls_stall();
    if_valid = 1'b1;
    if_inst  = 32'h0020A423;
    va = 1'b0;
    vl = 1'b0;
    tick();
    if_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (sb_valid !== 1'b0) $display("FAIL ls_stall_%0d: got %b want 0", c, sb_valid);
      else passes++;
      tick();
    end
    vl = 1'b1;
    @(negedge clk);
    checks++;
    if (sb_valid !== 1'b1) $display("FAIL ls_issue_valid: got %b want 1", sb_valid);
    else passes++;
    checks++;
    if ({sb_funct, sb_rs1, sb_rs2, sb_rd, sb_imm} !== {3'b010, 5'd1, 5'd2, 5'd0, 32'd8})
      $display("FAIL ls_fields: got %h %0d %0d %0d %h want 2 1 2 0 00000008",
               sb_funct, sb_rs1, sb_rs2, sb_rd, sb_imm);
    else passes++;
    tick();
    vl = 1'b0;
  endtask

  task automatic test_branch();
    if_valid = 1'b1;
    if_inst  = 32'hFE208EE3;
    va = 1'b1;
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sb_valid !== 1'b1 || {sb_rs1, sb_rs2, sb_rd, sb_imm} !== {5'd1, 5'd2, 5'd0, 32'hFFFFFFFC})
      $display("FAIL branch_fields: got v=%b %0d %0d %0d %h want 1 1 2 0 fffffffc",
               sb_valid, sb_rs1, sb_rs2, sb_rd, sb_imm);
    else passes++;
    tick();
    va = 1'b0;
  endtask

  task automatic test_full_wrap();
    logic [31:0] words [10];
    int          idx;
    int          issued;
    for (int i = 0; i < 10; i++) words[i] = rand_word(1'b0);
    va = 1'b0;
    vl = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if_valid = (idx < 5);
      if_inst  = (idx < 10) ? words[idx] : 32'h0;
      @(negedge clk);
      checks++;
      if (if_ready !== (q.size() != DEPTH))
        $display("FAIL full_ready_%0d: got %b want %b", c, if_ready, q.size() != DEPTH);
      else passes++;
      if (if_valid && if_ready) idx++;
      tick();
    end
    checks++;
    if (idx != 4 || if_ready !== 1'b0)
      $display("FAIL full_held: got pushes=%0d ready=%b want 4 0", idx, if_ready);
    else passes++;
    va = 1'b1;
    vl = 1'b1;
    issued = 0;
    for (int c = 0; c < 40 && issued < 10; c++) begin
      if_valid = (idx < 10);
      if_inst  = (idx < 10) ? words[idx] : 32'h0;
      @(negedge clk);
      checks++;
      if (sb_valid !== exp_valid())
        $display("FAIL wrap_valid_%0d: got %b want %b", c, sb_valid, exp_valid());
      else passes++;
      if (sb_valid === 1'b1) begin
        checks++;
        if ({sb_opt, sb_funct, sb_rs1, sb_rs2, sb_rd, sb_imm} !== exp_fields(words[issued]))
          $display("FAIL wrap_order_%0d: got %h want %h", issued,
                   {sb_opt, sb_funct, sb_rs1, sb_rs2, sb_rd, sb_imm}, exp_fields(words[issued]));
        else passes++;
        issued++;
      end
      if (if_valid && if_ready) idx++;
      tick();
    end
    if_valid = 1'b0;
    checks++;
    if (issued != 10) $display("FAIL wrap_count: got %0d issued want 10", issued);
    else passes++;
    va = 1'b0;
    vl = 1'b0;
  endtask

  task automatic test_unsupported();
    if_valid = 1'b1;
    if_inst  = 32'h00000037;
    va = 1'b1;
    tick();
    if_inst = 32'h00500093;
    @(negedge clk);
    checks++;
    if (sb_valid !== 1'b0 || bad_inst !== 1'b0)
      $display("FAIL bad_drop_cycle: got valid=%b bad=%b want 0 0", sb_valid, bad_inst);
    else passes++;
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bad_inst !== 1'b1) $display("FAIL bad_pulse: got %b want 1", bad_inst);
    else passes++;
    checks++;
    if (sb_valid !== 1'b1 || sb_rd !== 5'd1 || sb_imm !== 32'd5)
      $display("FAIL bad_next_issue: got v=%b rd=%0d imm=%h want 1 1 00000005",
               sb_valid, sb_rd, sb_imm);
    else passes++;
    tick();
    @(negedge clk);
    checks++;
    if (bad_inst !== 1'b0 || sb_valid !== 1'b0)
      $display("FAIL bad_pulse_end: got bad=%b valid=%b want 0 0", bad_inst, sb_valid);
    else passes++;
    tick();
    va = 1'b0;
  endtask

  task automatic test_flush();
    va = 1'b0;
    vl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1'b1;
      if_inst  = rand_word(1'b0);
      tick();
    end
    if_inst = 32'h00A00113;
    flush = 1'b1;
    va = 1'b1;
    vl = 1'b1;
    @(negedge clk);
    checks++;
    if (sb_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", sb_valid);
    else passes++;
    tick();
    flush = 1'b0;
    if_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (sb_valid !== 1'b0 || if_ready !== 1'b1 || bad_inst !== 1'b0)
        $display("FAIL flush_empty_%0d: got valid=%b ready=%b bad=%b want 0 1 0",
                 c, sb_valid, if_ready, bad_inst);
      else passes++;
      tick();
    end
    va = 1'b0;
    vl = 1'b0;
  endtask

  task automatic test_random();
    logic [56:0] exp;
    for (int c = 0; c < 300; c++) begin
      if_valid = ($urandom_range(3, 0) != 0);
      if_inst  = rand_word(1'b1);
      va       = $urandom_range(1, 0) == 1;
      vl       = $urandom_range(1, 0) == 1;
      flush    = ($urandom_range(15, 0) == 0);
      @(negedge clk);
      checks++;
      if (if_ready !== (q.size() != DEPTH) || sb_valid !== exp_valid() || bad_inst !== m_bad)
        $display("FAIL rand_ctrl_%0d: got ready=%b valid=%b bad=%b want %b %b %b", c,
                 if_ready, sb_valid, bad_inst, q.size() != DEPTH, exp_valid(), m_bad);
      else passes++;
      if (exp_valid()) begin
        exp = exp_fields(q[0]);
        checks++;
        if ({sb_opt, sb_funct, sb_rs1, sb_rs2, sb_rd, sb_imm} !== exp)
          $display("FAIL rand_fields_%0d: got %h want %h", c,
                   {sb_opt, sb_funct, sb_rs1, sb_rs2, sb_rd, sb_imm}, exp);
        else passes++;
      end
      tick();
    end
    if_valid = 1'b0;
    va = 1'b0;
    vl = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    if_valid = 1'b1;
    if_inst  = 32'h00500093;
    va = 1'b1;
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sb_valid !== 1'b1) $display("FAIL areset_pre_valid: got %b want 1", sb_valid);
    else passes++;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (sb_valid !== 1'b0 || if_ready !== 1'b1)
      $display("FAIL areset_immediate: got valid=%b ready=%b want 0 1", sb_valid, if_ready);
    else passes++;
    q.delete();
    m_bad = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sb_valid !== 1'b0 || bad_inst !== 1'b0)
      $display("FAIL areset_discard: got valid=%b bad=%b want 0 0", sb_valid, bad_inst);
    else passes++;
    tick();
    va = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_ls_stall();
    test_branch();
    test_full_wrap();
    test_unsupported();
    test_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/i_buffer.md
# i_buffer

Instruction buffer between fetch and the scoreboard. Queues raw 32-bit RV32I words from fetch in a small circular FIFO, decodes the head entry into opcode, funct3, register indices and a sign-extended immediate, and issues it to the scoreboard when the matching scoreboard partition (ALU or LS) has a vacant entry. Unsupported opcodes are dropped and flagged. A synchronous flush empties the buffer.

## Interface
- DEPTH_WIDTH, 2, log2 of FIFO depth (DEPTH = 2**DEPTH_WIDTH = 4)
- DATA_WIDTH, 32, instruction and immediate width

- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- if_valid  input  1  fetch presents a word this cycle
- if_inst  input  32  raw instruction word
- if_ready  output  1  buffer not full; a push happens only when if_valid && if_ready
- flush  input  1  synchronous clear of all buffered entries
- sb_vacant_ALU  input  1  scoreboard ALU partition has a free entry
- sb_vacant_LS  input  1  scoreboard LS queue has a free entry
- sb_valid  output  1  head instruction issued this cycle; the scoreboard accepts it unconditionally at the next edge
- sb_opt  output  7  opcode, inst[6:0]
- sb_funct  output  3  inst[14:12]
- sb_rs1 / sb_rs2 / sb_rd  output  5 each  register indices
- sb_imm  output  32  sign-extended immediate
- bad_inst  output  1  one-cycle pulse: an unsupported opcode was dropped

## Operation
- Storage is DEPTH entries plus head pointer, tail pointer (DEPTH_WIDTH bits, natural wrap) and count (DEPTH_WIDTH+1 bits).
- if_ready = (count != DEPTH), from registered count only. A push and a pop in the same cycle are allowed when not full. count is unchanged on push+pop.
- Classes by head opcode: ALU = B 1100011, I 0010011, R 0110011; LS = L 0000011, S 0100011; anything else is unsupported.
- sb_valid = (count != 0) && !flush && ((ALU && sb_vacant_ALU) || (LS && sb_vacant_LS)). This path is combinational, because the scoreboard's vacancy is itself combinational.
- Pop at the edge when sb_valid=1, or when the head is unsupported and there is no flush. An unsupported head is popped with sb_valid=0, and bad_inst is registered high for the following cycle.
- Decode is combinational from the head entry:
  - rs1 = inst[19:15] for all five classes.
  - rs2 = inst[24:20] for R/B/S, 0 for I/L.
  - rd = inst[11:7] for R/I/L, 0 for B/S.
  - imm for I/L: sext(inst[31:20]).
  - imm for S: sext({inst[31:25], inst[11:7]}).
  - imm for B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - imm for R: 0.
- sb_* fields are don't-care when sb_valid=0, but must be stable, glitch-free register/decode functions of the head.
- flush has highest priority:
  - Head, tail and count go to 0.
  - A coincident push is discarded.
  - sb_valid is forced 0 in the flush cycle.
  - bad_inst is not raised.

## Timing
- Reset (rst low, asynchronous): head=tail=count=0, bad_inst=0, every entry cleared to 0.
  - While reset is asserted, if_ready reads 1 and sb_valid reads 0.
  - Fetch holds if_valid low during reset.
- Push-to-issue latency: a word pushed at edge k can drive sb_valid=1 in the cycle after edge k, at the earliest.
- Throughput is one issue per cycle while the vacancy for the head's class holds.
- A head whose class is not vacant stalls. Younger entries never bypass it, so issue is strictly in order.
- Full: count=DEPTH drops if_ready. Becoming not-full because of a pop takes effect the cycle after that pop.
- Empty: sb_valid=0 regardless of the vacancy inputs.
- Pointers wrap from DEPTH-1 to 0 with no bubble.
- Reset mid-stream discards all entries immediately, with no partial issue.

## Test plan
- Single issue:
  - Stimulus: push 0x00500093 (addi x1,x0,5) with sb_vacant_ALU=1.
  - Response: the next cycle has sb_valid=1, opt=0010011, funct=0, rd=1, rs1=0, rs2=0, imm=5. The cycle after that has count=0.
- LS stall:
  - Stimulus: push 0x0020A423 (sw x2,8(x1)) with sb_vacant_LS=0 for 3 cycles, then 1.
  - Response: sb_valid stays 0 for those 3 cycles, then goes to 1 with rs1=1, rs2=2, rd=0, imm=8, funct=010.
- Branch immediate:
  - Stimulus: push 0xFE208EE3 (beq x1,x2,-4).
  - Response: imm=0xFFFFFFFC, rs1=1, rs2=2, rd=0.
- Full and wrap:
  - Stimulus: both vacancies 0; push 5 words.
  - Response: if_ready falls after the 4th push and the 5th word is held by fetch. Then set vacancies to 1 and push 6 more: all 10 words issue in push order across a pointer wrap.
- Unsupported opcode:
  - Stimulus: push 0x00000037 (LUI), then the addi above.
  - Response: LUI is dropped with sb_valid=0 and bad_inst pulses 1 cycle. The addi issues on the cycle after the drop.
- Flush:
  - Stimulus: with 3 entries buffered, assert flush coincident with a push.
  - Response: sb_valid=0 in that cycle, count=0 afterwards, and the pushed word never issues.
- Async reset mid-operation:
  - Stimulus: pull rst low between clock edges while sb_valid=1.
  - Response: sb_valid falls immediately and if_ready=1.
